// File: rtl/noc_ejection_buffer.sv
// Router ejection stage: credit-fed FIFO, valid/ready output, framing and overflow checks.
// Optional statistics counters are enabled by defining NOC_EJECT_STATS_EN.
//
// state | meaning
// IDLE  | between packets; the next accepted flit is a head
// BODY  | inside a packet; accepted flits must carry the head's dest
module noc_ejection_buffer #(
  parameter int FLIT_WIDTH   = 64,
  parameter int DEST_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk_noc,
  input  logic                  rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [FLIT_WIDTH-1:0] out_tdata,
  output logic [DEST_WIDTH-1:0] out_tdest,
  output logic                  out_tlast,
  output logic                  err_overflow,
  output logic                  err_dest_mismatch
`ifdef NOC_EJECT_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  flit_count
`endif
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(BUFFER_DEPTH - 1);

  if (BUFFER_DEPTH < 2 || CNT_WIDTH < 1) begin : g_bad_param
    $error("noc_ejection_buffer: BUFFER_DEPTH must be >= 2 and CNT_WIDTH >= 1");
  end

  typedef enum logic {IDLE = 1'b0, BODY = 1'b1} state_t;

  logic [FLIT_WIDTH-1:0] data_mem [BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0] dest_mem [BUFFER_DEPTH];
  logic                  tail_mem [BUFFER_DEPTH];

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  overflow;

  state_t                state_q;
  state_t                state_d;
  logic [DEST_WIDTH-1:0] pkt_dest_q;
  logic [DEST_WIDTH-1:0] pkt_dest_d;
  logic                  mismatch;

  assign full       = (count == DEPTH_C);
  assign out_tvalid = (count != '0);
  assign pop        = out_tvalid & out_tready;
  // A pop frees the head slot this cycle, so a full FIFO can still accept.
  assign push       = send_in & (~full | pop);
  assign overflow   = send_in & full & ~pop;

  assign out_tdata  = data_mem[rd_ptr];
  assign out_tdest  = dest_mem[rd_ptr];
  assign out_tlast  = tail_mem[rd_ptr];

  always_ff @(posedge clk_noc) begin
    if (push) begin
      data_mem[wr_ptr] <= data_in;
      dest_mem[wr_ptr] <= dest_in;
      tail_mem[wr_ptr] <= is_tail_in;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      credit_out   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      credit_out <= pop;
      if (overflow) err_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pkt_dest_d = pkt_dest_q;
    mismatch   = 1'b0;
    if (push) begin
      case (state_q)
        IDLE: begin
          pkt_dest_d = dest_in;
          if (!is_tail_in) state_d = BODY;
        end
        BODY: begin
          mismatch = (dest_in != pkt_dest_q);
          if (is_tail_in) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      state_q           <= IDLE;
      pkt_dest_q        <= '0;
      err_dest_mismatch <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_dest_q <= pkt_dest_d;
      if (mismatch) err_dest_mismatch <= 1'b1;
    end
  end

`ifdef NOC_EJECT_STATS_EN
  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      pkt_count  <= '0;
      flit_count <= '0;
    end else if (pop) begin
      flit_count <= flit_count + CNT_WIDTH'(1);
      if (out_tlast) pkt_count <= pkt_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_noc_ejection_buffer.sv
// Directed bench for noc_ejection_buffer: vector table for basic flow, hand sequences for corners.
// Statistics checks compile only when NOC_EJECT_STATS_EN is defined.
module tb_noc_ejection_buffer;

  logic        clk_noc = 1'b0;
  logic        rst_noc_sync;
  logic [63:0] data_in;
  logic [5:0]  dest_in;
  logic        is_tail_in;
  logic        send_in;
  logic        credit_out;
  logic        out_tvalid;
  logic        out_tready;
  logic [63:0] out_tdata;
  logic [5:0]  out_tdest;
  logic        out_tlast;
  logic        err_overflow;
  logic        err_dest_mismatch;
`ifdef NOC_EJECT_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] flit_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_noc = ~clk_noc;

  noc_ejection_buffer dut (
    .clk_noc           (clk_noc),
    .rst_noc_sync      (rst_noc_sync),
    .data_in           (data_in),
    .dest_in           (dest_in),
    .is_tail_in        (is_tail_in),
    .send_in           (send_in),
    .credit_out        (credit_out),
    .out_tvalid        (out_tvalid),
    .out_tready        (out_tready),
    .out_tdata         (out_tdata),
    .out_tdest         (out_tdest),
    .out_tlast         (out_tlast),
    .err_overflow      (err_overflow),
    .err_dest_mismatch (err_dest_mismatch)
`ifdef NOC_EJECT_STATS_EN
    ,
    .pkt_count         (pkt_count),
    .flit_count        (flit_count)
`endif
  );

  typedef struct packed {
    logic        send;
    logic [63:0] data;
    logic [5:0]  dest;
    logic        tail;
    logic        tready;
    logic        e_valid;
    logic [63:0] e_data;
    logic        e_last;
    logic        e_credit;
  } vec_t;

  vec_t vecs [0:12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_noc);
    #1;
  endtask

  task automatic drive(input logic s, input logic [63:0] d, input logic [5:0] ds,
                       input logic t, input logic r);
    send_in    = s;
    data_in    = d;
    dest_in    = ds;
    is_tail_in = t;
    out_tready = r;
  endtask

  task automatic do_reset();
    drive(1'b0, 64'h0, 6'h0, 1'b0, 1'b0);
    rst_noc_sync = 1'b1;
    step();
    step();
    rst_noc_sync = 1'b0;
  endtask

  initial begin
    // send data dest tail tready | valid data last credit (state after the edge)
    vecs[0]  = '{1'b1, 64'hA5, 6'h05, 1'b1, 1'b1, 1'b1, 64'hA5, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 64'h0,  6'h00, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1};
    vecs[2]  = '{1'b0, 64'h0,  6'h00, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 64'h10, 6'h05, 1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 64'h11, 6'h05, 1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 64'h12, 6'h05, 1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 64'h13, 6'h05, 1'b1, 1'b0, 1'b1, 64'h10, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 64'h0,  6'h00, 1'b0, 1'b0, 1'b1, 64'h10, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 64'h0,  6'h00, 1'b0, 1'b1, 1'b1, 64'h11, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 64'h0,  6'h00, 1'b0, 1'b1, 1'b1, 64'h12, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 64'h0,  6'h00, 1'b0, 1'b1, 1'b1, 64'h13, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 64'h0,  6'h00, 1'b0, 1'b1, 1'b0, 64'h0,  1'b0, 1'b1};
    vecs[12] = '{1'b0, 64'h0,  6'h00, 1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 1'b0};

    do_reset();
    chk("rst_valid", out_tvalid, 1'b0);
    chk("rst_credit", credit_out, 1'b0);
    chk("rst_ovf", err_overflow, 1'b0);
    chk("rst_dm", err_dest_mismatch, 1'b0);
    chk("rst_state", 64'(dut.state_q), 64'd0);
`ifdef NOC_EJECT_STATS_EN
    chk("rst_pkt_count", pkt_count, 16'd0);
    chk("rst_flit_count", flit_count, 16'd0);
`endif

    // Tests 1 and 2: single-flit packet, then fill to 4 with stalled consumer and drain
    for (int i = 0; i <= 12; i++) begin
      drive(vecs[i].send, vecs[i].data, vecs[i].dest, vecs[i].tail, vecs[i].tready);
      step();
      chk($sformatf("vec%0d_valid", i), out_tvalid, vecs[i].e_valid);
      chk($sformatf("vec%0d_credit", i), credit_out, vecs[i].e_credit);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_data", i), out_tdata, vecs[i].e_data);
        chk($sformatf("vec%0d_last", i), out_tlast, vecs[i].e_last);
        chk($sformatf("vec%0d_dest", i), out_tdest, 6'h05);
      end
      if (i == 6) chk("t2_count_full", 64'(dut.count), 64'd4);
    end
    chk("t12_ovf", err_overflow, 1'b0);
    chk("t12_dm", err_dest_mismatch, 1'b0);

    // Test 3: overflow drops the 5th flit and does not advance the FSM
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h30 + 64'(i), 6'h05, (i == 3), 1'b0);
      step();
    end
    drive(1'b1, 64'hFF, 6'h2A, 1'b0, 1'b0);
    step();
    chk("t3_ovf_set", err_overflow, 1'b1);
    chk("t3_count", 64'(dut.count), 64'd4);
    chk("t3_state_idle", 64'(dut.state_q), 64'd0);
    chk("t3_dm", err_dest_mismatch, 1'b0);
    drive(1'b0, 64'h0, 6'h0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) step();
    chk("t3_ovf_sticky", err_overflow, 1'b1);
    chk("t3_head_stable", out_tdata, 64'h30);
    out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_drain%0d_valid", i), out_tvalid, 1'b1);
      chk($sformatf("t3_drain%0d_data", i), out_tdata, 64'h30 + 64'(i));
      step();
      chk($sformatf("t3_drain%0d_credit", i), credit_out, 1'b1);
    end
    chk("t3_empty", out_tvalid, 1'b0);

    // Test 4: push and pop together while full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h20 + 64'(i), 6'h05, 1'b1, 1'b0);
      step();
    end
    drive(1'b1, 64'h24, 6'h05, 1'b1, 1'b1);
    step();
    chk("t4_no_ovf", err_overflow, 1'b0);
    chk("t4_count", 64'(dut.count), 64'd4);
    chk("t4_credit", credit_out, 1'b1);
    drive(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t4_drain%0d_data", i), out_tdata, 64'h20 + 64'(i));
      step();
    end
    chk("t4_empty", out_tvalid, 1'b0);

    // Test 5: dest mismatch inside a packet, then a clean packet
    do_reset();
    drive(1'b1, 64'h50, 6'h05, 1'b0, 1'b1);
    step();
    chk("t5_state_body", 64'(dut.state_q), 64'd1);
    drive(1'b1, 64'h51, 6'h05, 1'b0, 1'b1);
    step();
    chk("t5_dm_clean", err_dest_mismatch, 1'b0);
    drive(1'b1, 64'h52, 6'h07, 1'b1, 1'b1);
    step();
    chk("t5_dm_set", err_dest_mismatch, 1'b1);
    chk("t5_state_idle", 64'(dut.state_q), 64'd0);
    drive(1'b1, 64'h53, 6'h09, 1'b0, 1'b1);
    step();
    chk("t5_p2_body", 64'(dut.state_q), 64'd1);
    drive(1'b1, 64'h54, 6'h09, 1'b1, 1'b1);
    step();
    chk("t5_p2_idle", 64'(dut.state_q), 64'd0);
    chk("t5_dm_sticky", err_dest_mismatch, 1'b1);
    do_reset();
    drive(1'b1, 64'h55, 6'h09, 1'b0, 1'b1);
    step();
    drive(1'b1, 64'h56, 6'h09, 1'b1, 1'b1);
    step();
    chk("t5_clean_pkt_dm", err_dest_mismatch, 1'b0);
    drive(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
    step();
    step();

    // Test 6: reset mid-packet discards buffered flits
    do_reset();
    drive(1'b1, 64'h60, 6'h05, 1'b0, 1'b0);
    step();
    drive(1'b1, 64'h61, 6'h05, 1'b0, 1'b0);
    step();
    chk("t6_buffered", 64'(dut.count), 64'd2);
    chk("t6_state_body", 64'(dut.state_q), 64'd1);
    drive(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
    rst_noc_sync = 1'b1;
    step();
    rst_noc_sync = 1'b0;
    chk("t6_valid", out_tvalid, 1'b0);
    chk("t6_credit", credit_out, 1'b0);
    chk("t6_state_idle", 64'(dut.state_q), 64'd0);
    step();
    chk("t6_credit_after", credit_out, 1'b0);

`ifdef NOC_EJECT_STATS_EN
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, 64'h70 + 64'(p), 6'h05, 1'b0, 1'b1);
      step();
      drive(1'b1, 64'h80 + 64'(p), 6'h05, 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 64'h0, 6'h0, 1'b0, 1'b1);
    step();
    step();
    chk("stats_pkt_count", pkt_count, 16'd3);
    chk("stats_flit_count", flit_count, 16'd6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
